retire_trace_monitor: RTL and testbench
=======================================

Name: retire_trace_monitor

Overview:
- Sits between the single-cycle RISC-V core and the program-level checkers (e.g. the Fibonacci checker); watches fetch and writeback signals each cycle.
- Buffers register-file writes in a trace FIFO, which a consumer drains with valid/ready.
- Detects program end from consecutive NOP fetches and raises done once the trace is drained; also counts cycles/retired instructions and flags runaway programs by timeout.

Parameters:
DEPTH, 16, trace FIFO entries (power of 2, >=2)
NOP_WORD, 32'h00000013, instruction word marking program end
END_COUNT, 2, consecutive NOP_WORD fetches that end the program (>=1)
TIMEOUT_CYCLES, 100000, RUN cycles before timeout

Ports:
clk in 1 core clock
reset in 1 synchronous active-high reset
start in 1 one-cycle pulse; begins monitoring (honoured only in IDLE)
instr in 32 instruction memory output for current cycle
pc in 32 PC of current instruction
reg_write in 1 register bank write enable
rd in 5 destination register
wb_data in 32 data written to register bank
trace_ready in 1 consumer accepts head entry
trace_valid out 1 FIFO non-empty
trace_rd out 5 head entry rd
trace_data out 32 head entry data
trace_pc out 32 head entry pc
done out 1 program ended and FIFO drained (sticky)
timeout out 1 timeout hit (sticky)
overflow out 1 a write was dropped (sticky)
retired_count out 32 non-NOP instructions seen in RUN
cycle_count out 32 RUN cycles elapsed

Behaviour:
- Reset (synchronous, active-high): state IDLE, FIFO empty, all outputs 0, NOP run counter 0. Reset mid-RUN/DRAIN aborts immediately; FIFO contents lost.
- States: IDLE, RUN, DRAIN, DONE, TOUT.
- IDLE: start=1 -> RUN next cycle; counters cleared on that edge. First sampled cycle is the first cycle in RUN.
- RUN, every cycle:
  - cycle_count+1.
  - instr!=NOP_WORD: retired_count+1 and NOP run counter cleared; otherwise NOP run counter+1.
  - reg_write=1 and rd!=0: push {pc,rd,wb_data}. Writes to x0 are never captured, including NOP_WORD.
- RUN exits:
  - NOP run counter reaches END_COUNT (the END_COUNT-th consecutive NOP is sampled) -> DRAIN.
  - Otherwise cycle_count==TIMEOUT_CYCLES-1 at the edge -> TOUT.
  - End detection has priority over timeout in the same cycle.
- DRAIN: no pushes. When FIFO empty -> DONE; done=1 the cycle after the last pop.
- DONE: done=1 until reset; start ignored.
- TOUT: timeout=1 until reset; no pushes; consumer may still pop.
- FIFO:
  - Head presented combinationally from storage; trace_valid=!empty.
  - Pop occurs when trace_valid&&trace_ready.
  - Push when full without same-cycle pop: entry dropped, overflow=1 sticky.
  - Push+pop same cycle when full: both succeed, count unchanged.
  - Push+pop when empty: push only (no bypass); entry visible next cycle.
  - Pointers wrap modulo DEPTH.
- Counters are 32-bit and saturate at 32'hFFFFFFFF.
- Latency: entry pushed at edge N is visible on trace_* after edge N.

Optional Feature:
- TRACE_CHECKSUM_EN defined: extra output port checksum (out, 32).
  - checksum = sum mod 2^32 of wb_data of every entry actually pushed (dropped entries excluded).
  - Cleared at reset and on start; frozen outside RUN.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- start, 5 instrs with writes x1..x5=10,20,30,40,50, then 2 NOPs, trace_ready=1 -> 5 entries in order, retired_count=5, cycle_count=7, done=1 after last pop.
- Write to x0 with wb_data=32'hDEADBEEF, then a write to x3=7 -> only the x3 entry appears.
- trace_ready=0, 20 writes, DEPTH=16 -> entries 1..16 kept, overflow=1; after end plus draining 16 entries -> done=1.
- Full FIFO, trace_ready=1 with push same cycle -> count stays 16, overflow stays 0, order preserved.
- NOP, non-NOP, NOP (END_COUNT=2) -> no end; stays RUN. TIMEOUT_CYCLES=50 with no NOP pair -> timeout=1 after 50 RUN cycles, done=0.
- Reset asserted in DRAIN with 3 entries pending -> next cycle trace_valid=0, all outputs 0, state IDLE; with TRACE_CHECKSUM_EN, writes 1,2,3 -> checksum=6.

Source files
------------

// File: rtl/retire_trace_monitor.sv
// Retire trace monitor: captures register-file writes of a single-cycle core into a
// trace FIFO and detects program end or timeout. Define TRACE_CHECKSUM_EN for a checksum port.
module retire_trace_monitor #(
  parameter int unsigned DEPTH          = 16,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0013,
  parameter int unsigned END_COUNT      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic [31:0] wb_data,
  input  logic        trace_ready,
  output logic        trace_valid,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_data,
  output logic [31:0] trace_pc,
  output logic        done,
  output logic        timeout,
  output logic        overflow,
`ifdef TRACE_CHECKSUM_EN
  output logic [31:0] checksum,
`endif
  output logic [31:0] retired_count,
  output logic [31:0] cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = $clog2(END_COUNT + 1);
  localparam logic [CW-1:0] FULL_CNT     = CW'(DEPTH);
  localparam logic [NW:0]   END_CNT      = (NW + 1)'(END_COUNT);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_TOUT  = 3'd4
  } state_t;

  state_t        state_r, state_next_s;
  logic [CW-1:0] count_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [31:0]   mem_pc_r   [DEPTH];
  logic [4:0]    mem_rd_r   [DEPTH];
  logic [31:0]   mem_data_r [DEPTH];
  logic [NW-1:0] nop_cnt_r;
  logic [31:0]   cycle_cnt_r, retired_cnt_r, checksum_r;
  logic          done_r, timeout_r, overflow_r;

  logic          run_s, is_nop_s, end_hit_s, nonempty_s, full_s;
  logic          pop_s, push_req_s, push_ok_s, drop_s, drain_empty_s;
  logic [NW:0]   nop_plus_s;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; end-of-program detection wins over timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  state_next_s = start ? S_RUN : S_IDLE;
      S_RUN: begin
        if (end_hit_s) begin
          state_next_s = S_DRAIN;
        end else if (cycle_cnt_r == TIMEOUT_LAST) begin
          state_next_s = S_TOUT;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_DRAIN: state_next_s = drain_empty_s ? S_DONE : S_DRAIN;
      S_DONE:  state_next_s = S_DONE;
      S_TOUT:  state_next_s = S_TOUT;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Per-state control decode and FIFO handshake qualification.
  always_comb begin
    run_s      = 1'b0;
    push_req_s = 1'b0;
    end_hit_s  = 1'b0;
    is_nop_s   = (instr == NOP_WORD);
    nop_plus_s = {1'b0, nop_cnt_r} + {{NW{1'b0}}, 1'b1};
    nonempty_s = (count_r != {CW{1'b0}});
    full_s     = (count_r == FULL_CNT);
    pop_s      = nonempty_s && trace_ready;
    case (state_r)
      S_RUN: begin
        run_s      = 1'b1;
        push_req_s = reg_write && (rd != 5'd0);
        end_hit_s  = is_nop_s && (nop_plus_s == END_CNT);
      end
      default: begin
        run_s      = 1'b0;
        push_req_s = 1'b0;
        end_hit_s  = 1'b0;
      end
    endcase
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok_s     = push_req_s && (!full_s || pop_s);
    drop_s        = push_req_s && full_s && !pop_s;
    drain_empty_s = !nonempty_s || ((count_r == {{(CW-1){1'b0}}, 1'b1}) && pop_s);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_pc_r[wr_ptr_r]   <= pc;
      mem_rd_r[wr_ptr_r]   <= rd;
      mem_data_r[wr_ptr_r] <= wb_data;
    end
  end

  // Run counters, NOP run length, checksum and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_r   <= 32'd0;
      retired_cnt_r <= 32'd0;
      nop_cnt_r     <= {NW{1'b0}};
      checksum_r    <= 32'd0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) && start) begin
        cycle_cnt_r   <= 32'd0;
        retired_cnt_r <= 32'd0;
        nop_cnt_r     <= {NW{1'b0}};
        checksum_r    <= 32'd0;
      end else if (run_s) begin
        cycle_cnt_r <= sat_inc(cycle_cnt_r);
        if (is_nop_s) begin
          nop_cnt_r <= nop_plus_s[NW-1:0];
        end else begin
          nop_cnt_r     <= {NW{1'b0}};
          retired_cnt_r <= sat_inc(retired_cnt_r);
        end
        if (push_ok_s) begin
          checksum_r <= checksum_r + wb_data;
        end
      end
      if (state_next_s == S_DONE) begin
        done_r <= 1'b1;
      end
      if (state_next_s == S_TOUT) begin
        timeout_r <= 1'b1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Head is shown straight from storage; zeroed while empty so reset clears every output.
  assign trace_valid   = nonempty_s;
  assign trace_rd      = nonempty_s ? mem_rd_r[rd_ptr_r]   : 5'd0;
  assign trace_data    = nonempty_s ? mem_data_r[rd_ptr_r] : 32'd0;
  assign trace_pc      = nonempty_s ? mem_pc_r[rd_ptr_r]   : 32'd0;
  assign done          = done_r;
  assign timeout       = timeout_r;
  assign overflow      = overflow_r;
  assign retired_count = retired_cnt_r;
  assign cycle_count   = cycle_cnt_r;
`ifdef TRACE_CHECKSUM_EN
  assign checksum      = checksum_r;
`else
  logic unused_checksum_s;
  assign unused_checksum_s = ^checksum_r;
`endif

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed self-checking bench for retire_trace_monitor (DEPTH=16, END_COUNT=2, TIMEOUT_CYCLES=50).
module tb_retire_trace_monitor;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ALU = 32'h00A0_0093;

  logic        clk = 1'b0;
  logic        reset, start, reg_write, trace_ready;
  logic [31:0] instr, pc, wb_data;
  logic [4:0]  rd;
  logic        trace_valid, done, timeout, overflow;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data, trace_pc, retired_count, cycle_count;
`ifdef TRACE_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t got[$];

  retire_trace_monitor #(.DEPTH(16), .NOP_WORD(32'h0000_0013), .END_COUNT(2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
    .reg_write(reg_write), .rd(rd), .wb_data(wb_data), .trace_ready(trace_ready),
    .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_data(trace_data), .trace_pc(trace_pc),
    .done(done), .timeout(timeout), .overflow(overflow),
`ifdef TRACE_CHECKSUM_EN
    .checksum(checksum),
`endif
    .retired_count(retired_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Records the head when it is popped on the coming edge, then advances one cycle.
  task automatic tick();
    if (trace_valid === 1'b1 && trace_ready === 1'b1) got.push_back(ent_t'({trace_pc, trace_rd, trace_data}));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic w, input logic [4:0] r,
                       input logic [31:0] d, input logic [31:0] p);
    instr = i; reg_write = w; rd = r; wb_data = d; pc = p;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; trace_ready = 1'b0; reg_write = 1'b0;
    instr = ALU; rd = 5'd0; wb_data = 32'd0; pc = 32'd0;
    tick(); tick();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    reg_write = 1'b0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({trace_valid, done, timeout, overflow} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {trace_valid, done, timeout, overflow}); end
    checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin errors++;
      $display("FAIL reset_counters: got cyc=%0d ret=%0d expected 0/0", cycle_count, retired_count); end
  endtask

  task automatic test_basic();
    do_reset();
    trace_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 5; i++) drive(ALU, 1'b1, 5'(i), 32'(10 * i), 32'h100 + 32'(4 * i));
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h200);
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h204);
    wait_done(20);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
    checks++; if (cycle_count !== 32'd7) begin errors++; $display("FAIL basic_cycles: got %0d expected 7", cycle_count); end
    checks++; if (retired_count !== 32'd5) begin errors++; $display("FAIL basic_retired: got %0d expected 5", retired_count); end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL basic_entries: got %0d expected 5", got.size()); end
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (i > got.size()) begin errors++; $display("FAIL basic_entry%0d: got none expected rd=%0d", i, i); end
      else if (got[i-1] !== ent_t'({32'h100 + 32'(4 * i), 5'(i), 32'(10 * i)})) begin errors++;
        $display("FAIL basic_entry%0d: got pc=%h rd=%0d data=%0d expected pc=%h rd=%0d data=%0d", i,
                 got[i-1].pc, got[i-1].rd, got[i-1].data, 32'h100 + 32'(4 * i), i, 10 * i); end
    end
`ifdef TRACE_CHECKSUM_EN
    checks++; if (checksum !== 32'd150) begin errors++; $display("FAIL basic_checksum: got %0d expected 150", checksum); end
`endif
    pulse_start();
    checks++; if (done !== 1'b1 || cycle_count !== 32'd7) begin errors++;
      $display("FAIL done_ignores_start: got done=%b cyc=%0d expected 1/7", done, cycle_count); end
  endtask

  task automatic test_x0();
    do_reset();
    trace_ready = 1'b1;
    pulse_start();
    drive(ALU, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h40);
    drive(ALU, 1'b1, 5'd3, 32'd7, 32'h44);
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h48);
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h4C);
    wait_done(20);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL x0_entries: got %0d expected 1", got.size()); end
    else if (got[0].rd !== 5'd3 || got[0].data !== 32'd7) begin errors++;
      $display("FAIL x0_entry: got rd=%0d data=%h expected rd=3 data=7", got[0].rd, got[0].data); end
`ifdef TRACE_CHECKSUM_EN
    checks++; if (checksum !== 32'd7) begin errors++; $display("FAIL x0_checksum: got %h expected 7", checksum); end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    pulse_start();
    for (int i = 1; i <= 20; i++) drive(ALU, 1'b1, 5'(i), 32'(i), 32'(4 * i));
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h80);
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h84);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (trace_valid !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL ovf_drain_state: got valid=%b done=%b expected 1/0", trace_valid, done); end
    checks++; if (cycle_count !== 32'd22 || retired_count !== 32'd20) begin errors++;
      $display("FAIL ovf_counters: got cyc=%0d ret=%0d expected 22/20", cycle_count, retired_count); end
    trace_ready = 1'b1;
    wait_done(40);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b expected 1", done); end
    checks++; if (got.size() != 16) begin errors++; $display("FAIL ovf_entries: got %0d expected 16", got.size()); end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (i > got.size() || got[i-1].data !== 32'(i) || got[i-1].rd !== 5'(i)) begin errors++;
        $display("FAIL ovf_entry%0d: expected rd=%0d data=%0d", i, i, i); end
    end
`ifdef TRACE_CHECKSUM_EN
    checks++; if (checksum !== 32'd136) begin errors++; $display("FAIL ovf_checksum: got %0d expected 136", checksum); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    for (int i = 1; i <= 16; i++) drive(ALU, 1'b1, 5'(i), 32'(100 + i), 32'(4 * i));
    checks++; if (overflow !== 1'b0 || trace_valid !== 1'b1) begin errors++;
      $display("FAIL full_fill: got ovf=%b valid=%b expected 0/1", overflow, trace_valid); end
    trace_ready = 1'b1;
    for (int i = 17; i <= 19; i++) drive(ALU, 1'b1, 5'(i), 32'(100 + i), 32'(4 * i));
    trace_ready = 1'b0;
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h90);
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h94);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b expected 0", overflow); end
    trace_ready = 1'b1;
    wait_done(40);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", done); end
    checks++; if (got.size() != 19) begin errors++; $display("FAIL full_entries: got %0d expected 19", got.size()); end
    for (int i = 1; i <= 19; i++) begin
      checks++;
      if (i > got.size() || got[i-1].data !== 32'(100 + i)) begin errors++;
        $display("FAIL full_entry%0d: expected data=%0d", i, 100 + i); end
    end
`ifdef TRACE_CHECKSUM_EN
    checks++; if (checksum !== 32'd2090) begin errors++; $display("FAIL full_checksum: got %0d expected 2090", checksum); end
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h0);
    drive(ALU, 1'b0, 5'd0, 32'd0, 32'h4);
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h8);
    checks++; if (cycle_count !== 32'd3 || retired_count !== 32'd1 || done !== 1'b0) begin errors++;
      $display("FAIL nop_gap: got cyc=%0d ret=%0d done=%b expected 3/1/0", cycle_count, retired_count, done); end
    for (int i = 4; i <= 49; i++) drive(ALU, 1'b0, 5'd0, 32'd0, 32'(4 * i));
    checks++; if (timeout !== 1'b0 || cycle_count !== 32'd49) begin errors++;
      $display("FAIL tout_early: got tout=%b cyc=%0d expected 0/49", timeout, cycle_count); end
    drive(ALU, 1'b0, 5'd0, 32'd0, 32'd200);
    checks++; if (timeout !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL tout_hit: got tout=%b done=%b expected 1/0", timeout, done); end
    checks++; if (cycle_count !== 32'd50 || retired_count !== 32'd48) begin errors++;
      $display("FAIL tout_counters: got cyc=%0d ret=%0d expected 50/48", cycle_count, retired_count); end
    drive(ALU, 1'b1, 5'd1, 32'd5, 32'd204);
    checks++; if (trace_valid !== 1'b0 || timeout !== 1'b1 || cycle_count !== 32'd50) begin errors++;
      $display("FAIL tout_frozen: got valid=%b tout=%b cyc=%0d expected 0/1/50", trace_valid, timeout, cycle_count); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    pulse_start();
    for (int i = 1; i <= 3; i++) drive(ALU, 1'b1, 5'(i), 32'(i), 32'(4 * i));
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h10);
    drive(NOP, 1'b0, 5'd0, 32'd0, 32'h14);
    checks++; if (trace_valid !== 1'b1 || trace_data !== 32'd1 || done !== 1'b0) begin errors++;
      $display("FAIL drain_pending: got valid=%b data=%0d done=%b expected 1/1/0", trace_valid, trace_data, done); end
`ifdef TRACE_CHECKSUM_EN
    checks++; if (checksum !== 32'd6) begin errors++; $display("FAIL drain_checksum: got %0d expected 6", checksum); end
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({trace_valid, done, timeout, overflow} !== 4'b0000 || trace_rd !== 5'd0 ||
                  trace_data !== 32'd0 || trace_pc !== 32'd0) begin errors++;
      $display("FAIL drain_reset_outputs: got valid=%b done=%b rd=%0d data=%h pc=%h expected all 0",
               trace_valid, done, trace_rd, trace_data, trace_pc); end
    checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin errors++;
      $display("FAIL drain_reset_counters: got cyc=%0d ret=%0d expected 0/0", cycle_count, retired_count); end
`ifdef TRACE_CHECKSUM_EN
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL drain_reset_checksum: got %0d expected 0", checksum); end
`endif
    drive(ALU, 1'b0, 5'd0, 32'd0, 32'd0);
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL idle_hold: got cyc=%0d expected 0", cycle_count); end
    pulse_start();
    drive(ALU, 1'b0, 5'd0, 32'd0, 32'd0);
    checks++; if (cycle_count !== 32'd1 || retired_count !== 32'd1) begin errors++;
      $display("FAIL restart: got cyc=%0d ret=%0d expected 1/1", cycle_count, retired_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
